mc_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-cycle register-file/ALU/data-memory datapath. It fetches each instruction from an external instruction memory over a req/ready handshake and latches it in an internal instruction register. It then steps the instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath's field and control inputs. It owns the PC, computes branch/jump targets, and supplies the link value for JAL.

---
 rtl/mc_sequencer_if.sv | 21 ++
 rtl/mc_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
interface mc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: fetches over a req/ready bus, steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives the datapath selects/strobes and owns the PC.
module mc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  mc_sequencer_if.master imem,
  output logic [4:0]     rs,
  output logic [4:0]     rt,
  output logic [4:0]     rd,
  output logic [15:0]    imm16,
  output logic           RegWr,
  output logic           MemWr,
  output logic           RegDst,
  output logic           ALUSrc,
  output logic           MemToReg,
  output logic           jl,
  output logic [2:0]     ALUCntrl,
  output logic [31:0]    pcStore,
  input  logic           zero,
  input  logic [31:0]    jRrs,
  output logic           retire,
  output logic [31:0]    instret,
  output logic           halted
);

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluXor = 3'b010;
  localparam logic [2:0] AluSlt = 3'b011;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;
  typedef enum logic [3:0] {KAlu, KImm, KLw, KSw, KBne, KJ, KJal, KJr, KIll} kind_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [2:0] alu_ctl;
    logic       mem_to_reg;
    logic       jl;
  } ctl_t;

  state_e      state_q;
  kind_e       kind_q;
  ctl_t        ctl_q;
  logic [31:0] pc_q;
  logic [25:0] ir_q;      // opcode/funct already folded into kind_q
  logic [31:0] instret_q;
  logic        halted_q;
  logic        reg_wr_q;
  logic        mem_wr_q;
  logic        retire_q;  // high throughout the instruction's last state

  kind_e       dec_kind;
  ctl_t        dec_ctl;
  logic [5:0]  dec_op;
  logic [5:0]  dec_fn;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] pc_next;

  assign dec_op = imem.imem_rdata[31:26];
  assign dec_fn = imem.imem_rdata[5:0];

  // Decode the word on the fetch bus so the selects are already registered in DECODE.
  always_comb begin
    dec_kind = KIll;
    dec_ctl  = '0;
    case (dec_op)
      6'h00: begin
        case (dec_fn)
          6'h20, 6'h22, 6'h2A: begin
            dec_kind        = KAlu;
            dec_ctl.reg_dst = 1'b1;
            dec_ctl.alu_src = 1'b1;
            dec_ctl.alu_ctl = (dec_fn == 6'h20) ? AluAdd : (dec_fn == 6'h22) ? AluSub : AluSlt;
          end
          6'h08:   dec_kind = KJr;
          default: dec_kind = KIll;
        endcase
      end
      6'h08: dec_kind = KImm;
      6'h0E: begin
        dec_kind        = KImm;
        dec_ctl.alu_ctl = AluXor;
      end
      6'h23: begin
        dec_kind           = KLw;
        dec_ctl.mem_to_reg = 1'b1;
      end
      6'h2B: dec_kind = KSw;
      6'h05: begin
        dec_kind        = KBne;
        dec_ctl.alu_src = 1'b1;
        dec_ctl.alu_ctl = AluSub;
      end
      6'h02: dec_kind = KJ;
      6'h03: begin
        dec_kind   = KJal;
        dec_ctl.jl = 1'b1;
      end
      default: dec_kind = KIll;
    endcase
  end

  // Next PC for the retiring instruction; zero/jRrs are live in the BNE/JR last state.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_target = pc_plus4 + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    j_target  = {pc_plus4[31:28], ir_q[25:0], 2'b00};
    pc_next   = pc_plus4;
    case (kind_q)
      KBne:    pc_next = zero ? pc_plus4 : br_target;
      KJ:      pc_next = j_target;
      KJal:    pc_next = j_target;
      KJr:     pc_next = jRrs;
      default: pc_next = pc_plus4;
    endcase
  end

  // Sequencer FSM; strobes and retire are registered for the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      kind_q    <= KIll;
      ctl_q     <= '0;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      reg_wr_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      mem_wr_q <= 1'b0;
      retire_q <= 1'b0;
      if (retire_q) begin
        state_q   <= StFetch;
        pc_q      <= pc_next;
        instret_q <= instret_q + 32'd1;
        ctl_q     <= '0;
      end else begin
        unique case (state_q)
          StFetch: begin
            if (imem.imem_ready) begin
              ir_q     <= imem.imem_rdata[25:0];
              kind_q   <= dec_kind;
              ctl_q    <= dec_ctl;
              state_q  <= StDecode;
              retire_q <= (dec_kind == KJ) || (dec_kind == KJr);
            end
          end
          StDecode: begin
            if (kind_q == KIll) begin
              state_q  <= StHalt;
              halted_q <= 1'b1;
            end else begin
              state_q  <= StExec;
              retire_q <= (kind_q == KBne);
            end
          end
          StExec: begin
            if ((kind_q == KLw) || (kind_q == KSw)) begin
              state_q  <= StMem;
              mem_wr_q <= (kind_q == KSw);
              retire_q <= (kind_q == KSw);
            end else begin
              state_q  <= StWb;
              reg_wr_q <= 1'b1;
              retire_q <= 1'b1;
            end
          end
          StMem: begin
            // Only LW is still in flight here.
            state_q  <= StWb;
            reg_wr_q <= 1'b1;
            retire_q <= 1'b1;
          end
          StWb:    state_q <= StFetch;
          StHalt:  state_q <= StHalt;
          default: state_q <= StFetch;
        endcase
      end
    end
  end

  // Outputs are forced to their reset values combinationally while reset is held.
  assign imem.imem_req  = (state_q == StFetch) && !reset;
  assign imem.imem_addr = reset ? RESET_PC : pc_q;
  assign rs             = reset ? 5'd0 : ir_q[25:21];
  assign rt             = reset ? 5'd0 : ir_q[20:16];
  assign rd             = reset ? 5'd0 : ir_q[15:11];
  assign imm16          = reset ? 16'd0 : ir_q[15:0];
  assign RegWr          = reg_wr_q && !reset;
  assign MemWr          = mem_wr_q && !reset;
  assign RegDst         = ctl_q.reg_dst && !reset;
  assign ALUSrc         = ctl_q.alu_src && !reset;
  assign MemToReg       = ctl_q.mem_to_reg && !reset;
  assign jl             = ctl_q.jl && !reset;
  assign ALUCntrl       = reset ? 3'd0 : ctl_q.alu_ctl;
  assign pcStore        = reset ? 32'd0 : pc_q + 32'd4;
  assign retire         = retire_q && !reset;
  assign instret        = reset ? 32'd0 : instret_q;
  assign halted         = halted_q && !reset;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed program plus random instruction stream,
// checked cycle by cycle against a table-driven reference model.
module tb_mc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic        RegWr, MemWr, RegDst, ALUSrc, MemToReg, jl;
  logic [2:0]  ALUCntrl;
  logic [31:0] pcStore;
  logic        zero;
  logic [31:0] jRrs;
  logic        retire;
  logic [31:0] instret;
  logic        halted;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] pc_m;
  logic [31:0] inst_m;

  mc_sequencer_if imem_bus ();

  mc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk      (clk),
    .reset    (reset),
    .imem     (imem_bus),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .imm16    (imm16),
    .RegWr    (RegWr),
    .MemWr    (MemWr),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .MemToReg (MemToReg),
    .jl       (jl),
    .ALUCntrl (ALUCntrl),
    .pcStore  (pcStore),
    .zero     (zero),
    .jRrs     (jRrs),
    .retire   (retire),
    .instret  (instret),
    .halted   (halted)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Expected per-instruction behaviour; sel = {RegDst, ALUSrc, ALUCntrl, MemToReg, jl}.
  typedef struct packed {
    logic       legal;
    logic [3:0] lat;
    logic       regwr;
    logic       memwr;
    logic [6:0] sel;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    r       = '0;
    r.legal = 1'b1;
    case (w[31:26])
      6'h00: begin
        case (w[5:0])
          6'h20: begin r.lat = 4'd4; r.regwr = 1'b1; r.sel = 7'b11_000_00; end
          6'h22: begin r.lat = 4'd4; r.regwr = 1'b1; r.sel = 7'b11_001_00; end
          6'h2A: begin r.lat = 4'd4; r.regwr = 1'b1; r.sel = 7'b11_011_00; end
          6'h08: r.lat = 4'd2;
          default: r.legal = 1'b0;
        endcase
      end
      6'h08: begin r.lat = 4'd4; r.regwr = 1'b1; r.sel = 7'b00_000_00; end
      6'h0E: begin r.lat = 4'd4; r.regwr = 1'b1; r.sel = 7'b00_010_00; end
      6'h23: begin r.lat = 4'd5; r.regwr = 1'b1; r.sel = 7'b00_000_10; end
      6'h2B: begin r.lat = 4'd4; r.memwr = 1'b1; r.sel = 7'b00_000_00; end
      6'h05: begin r.lat = 4'd3; r.sel = 7'b01_001_00; end
      6'h02: r.lat = 4'd2;
      6'h03: begin r.lat = 4'd4; r.regwr = 1'b1; r.sel = 7'b00_000_01; end
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] w, input logic [31:0] pc,
                                              input logic z, input logic [31:0] jr);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (w[31:26] == 6'h05 && !z) return p4 + ({{16{w[15]}}, w[15:0]} << 2);
    if (w[31:26] == 6'h02 || w[31:26] == 6'h03) return {p4[31:28], w[25:0], 2'b00};
    if (w[31:26] == 6'h00 && w[5:0] == 6'h08) return jr;
    return p4;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 19))
      0, 1:       begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
      2:          begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
      3:          begin w[31:26] = 6'h00; w[5:0] = 6'h2A; end
      4, 5:       w[31:26] = 6'h08;
      6:          w[31:26] = 6'h0E;
      7, 8:       w[31:26] = 6'h23;
      9, 10:      w[31:26] = 6'h2B;
      11, 12, 13: w[31:26] = 6'h05;
      14:         w[31:26] = 6'h02;
      15:         w[31:26] = 6'h03;
      16:         begin w[31:26] = 6'h00; w[5:0] = 6'h08; end
      17:         begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      18:         w[31:26] = 6'h3F;
      default:    ;
    endcase
    return w;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  // Hold reset for n cycles; entered and left just after a rising edge.
  task automatic do_reset(input int n);
    for (int c = 0; c < n; c++) begin
      reset                = 1'b1;
      imem_bus.imem_ready  = 1'($urandom);
      imem_bus.imem_rdata  = $urandom;
      zero                 = 1'($urandom);
      jRrs                 = $urandom;
      @(negedge clk);
      check_eq("rst_ctl", 32'({imem_bus.imem_req, RegWr, MemWr, retire, halted, RegDst, ALUSrc,
                               ALUCntrl, MemToReg, jl}), 32'd0);
      check_eq("rst_addr", imem_bus.imem_addr, RESET_PC);
      check_eq("rst_instret", instret, 32'd0);
      check_eq("rst_pcstore", pcStore, 32'd0);
      check_eq("rst_fields", 32'({rs, rt, rd, imm16}), 32'd0);
      @(posedge clk);
      #1;
    end
    reset  = 1'b0;
    pc_m   = RESET_PC;
    inst_m = 32'd0;
  endtask

  // Run one instruction with 'delay' not-ready fetch cycles. zero_mode: 0/1 fixed, 2 random.
  // abort_cyc > 0 asserts reset in that cycle and ends the instruction there.
  task automatic exec_instr(input logic [31:0] w, input int delay, input int zero_mode,
                            input logic [31:0] jr_v, input bit jr_rand, input int abort_cyc);
    ref_t        m;
    int          last;
    int          ncyc;
    logic        z_s;
    logic [31:0] jr_s;
    logic        rst_c;
    logic        fetch;
    logic [11:0] ev;
    m    = ref_decode(w);
    last = m.legal ? delay + int'(m.lat) : delay + 5;
    ncyc = (abort_cyc > 0) ? abort_cyc : last;
    z_s  = 1'b0;
    jr_s = 32'd0;
    for (int c = 1; c <= ncyc; c++) begin
      rst_c                = (c == abort_cyc);
      fetch                = (c <= delay + 1);
      reset                = rst_c;
      imem_bus.imem_ready  = (c <= delay) ? 1'b0 : (c == delay + 1) ? 1'b1 : 1'($urandom);
      imem_bus.imem_rdata  = (c == delay + 1) ? w : $urandom;
      zero                 = (zero_mode == 2) ? 1'($urandom) : zero_mode[0];
      jRrs                 = jr_rand ? $urandom : jr_v;
      if (c == delay + 2) jr_s = jRrs;
      if (c == delay + 3) z_s = zero;
      ev = '0;
      if (!rst_c) begin
        ev[11]  = fetch;
        ev[10]  = m.legal && m.regwr && (c == last);
        ev[9]   = m.legal && m.memwr && (c == last);
        ev[8]   = m.legal && (c == last);
        ev[7]   = !m.legal && (c >= delay + 3);
        ev[6:0] = (fetch || !m.legal) ? 7'd0 : m.sel;
      end
      @(negedge clk);
      check_eq("ctl", 32'({imem_bus.imem_req, RegWr, MemWr, retire, halted, RegDst, ALUSrc,
                           ALUCntrl, MemToReg, jl}), 32'(ev));
      check_eq("imem_addr", imem_bus.imem_addr, rst_c ? RESET_PC : pc_m);
      check_eq("instret", instret, rst_c ? 32'd0 : inst_m);
      check_eq("pcStore", pcStore, rst_c ? 32'd0 : pc_m + 32'd4);
      if (rst_c) check_eq("fields", 32'({rs, rt, rd, imm16}), 32'd0);
      else if (!fetch) check_eq("fields", 32'({rs, rt, rd, imm16}), 32'({w[25:11], w[15:0]}));
      @(posedge clk);
      #1;
    end
    if (abort_cyc > 0) begin
      pc_m   = RESET_PC;
      inst_m = 32'd0;
    end else if (m.legal) begin
      pc_m   = ref_next_pc(w, pc_m, z_s, jr_s);
      inst_m = inst_m + 32'd1;
    end
  endtask

  // Directed program from the plan, then a random instruction stream.
  initial begin
    ref_t        rm;
    logic [31:0] w;
    reset               = 1'b1;
    imem_bus.imem_ready = 1'b0;
    imem_bus.imem_rdata = 32'd0;
    zero                = 1'b0;
    jRrs                = 32'd0;
    pc_m                = RESET_PC;
    inst_m              = 32'd0;
    @(posedge clk);
    #1;
    do_reset(3);

    exec_instr(32'h2001_0005, 0, 2, 32'd0, 1'b1, 0);  // ADDI r1,r0,5
    check_eq("pc_after_addi", pc_m, 32'h44);
    exec_instr(32'h8C22_0004, 3, 2, 32'd0, 1'b1, 0);  // LW, ready after 3 cycles
    exec_instr(32'h0800_0040, 0, 2, 32'd0, 1'b1, 0);  // J -> 0x100
    exec_instr(32'h1400_FFFF, 1, 0, 32'd0, 1'b1, 0);  // BNE taken, back to 0x100
    exec_instr(32'h1400_FFFF, 0, 1, 32'd0, 1'b1, 0);  // BNE not taken -> 0x104
    exec_instr(32'h0800_0080, 0, 2, 32'd0, 1'b1, 0);  // J -> 0x200
    exec_instr(32'h0C00_0010, 0, 2, 32'd0, 1'b1, 0);  // JAL -> 0x40, pcStore 0x204
    exec_instr(32'h03E0_0008, 2, 2, 32'h204, 1'b0, 0); // JR r31 -> 0x204
    exec_instr(32'hFC00_0000, 1, 2, 32'd0, 1'b1, 0);  // illegal: halt
    do_reset(2);
    exec_instr(32'hAC22_0008, 0, 2, 32'd0, 1'b1, 0);  // SW
    exec_instr(32'h2001_0005, 0, 2, 32'd0, 1'b1, 4);  // ADDI aborted by reset in WB

    for (int i = 0; i < 120; i++) begin
      w  = rand_instr();
      rm = ref_decode(w);
      exec_instr(w, $urandom_range(0, 3), 2, 32'd0, 1'b1, 0);
      if (!rm.legal) do_reset($urandom_range(1, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
